// File: rtl/panel_loader.sv
// Front-panel program loader: parses a PAL BIN byte stream and replays it on the panel switches/buttons.
// Latency: 3*HOLD_CYCLES clocks per word (setup/pulse/release), plus 4*HOLD_CYCLES for the final PC load and run wait.
// Backpressure: byte_ready_o is high only while fetching a frame; the loader stalls the stream during button phases.
module panel_loader #(
  parameter int unsigned       HOLD_CYCLES = 10,
  parameter int unsigned       WORD_W      = 12,
  parameter logic [WORD_W-1:0] START_PC    = 12'o0200,
  parameter bit                AUTO_RUN    = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic [WORD_W-1:0] sw_o,
  output logic              deposit_o,
  output logic              load_pc_o,
  output logic              run_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_frame_o,
  output logic [CNT_W-1:0]  word_count_o
);

  // Phase counter is loaded with HOLD_CYCLES on entry and counts down to 1, so it never reaches 0 or wraps.
  localparam int unsigned   PH_W    = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(HOLD_CYCLES);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  typedef enum logic [3:0] {
    IDLE,
    GET_HI,
    GET_LO,
    SETUP,
    PULSE,
    RELEASE,
    FIN_SETUP,
    FIN_PULSE,
    FIN_RELEASE,
    RUN_WAIT,
    DONE,
    ERR
  } state_t;

  state_t              state_q;
  logic [PH_W-1:0]     phase_q;
  logic [5:0]          hi_q;       // high frame payload of the word being assembled
  logic                org_q;      // high frame carried the origin flag: this word is a PC load
  logic                fin_q;      // current word was the last one in the stream
  logic [WORD_W-1:0]   sw_q;
  logic                deposit_q;
  logic                load_pc_q;
  logic                run_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [CNT_W-1:0]    word_count_q;

  logic                xfer;
  logic                phase_end;
  logic [PH_W-1:0]     phase_d;
  logic [WORD_W-1:0]   word_d;
  logic [CNT_W-1:0]    word_count_d;

  // Bytes are only taken while a frame is being fetched; state is registered so this is glitch-free.
  assign byte_ready_o = (state_q == GET_HI) || (state_q == GET_LO);
  assign xfer         = byte_valid_i && byte_ready_o;

  assign phase_end    = (phase_q == PH_ONE);
  assign phase_d      = phase_q - PH_ONE;
  assign word_d       = WORD_W'({hi_q, byte_data_i[5:0]});
  // Deposit counter sticks at all-ones rather than wrapping.
  assign word_count_d = (word_count_q == '1) ? word_count_q : word_count_q + CNT_W'(1);

  // Loader FSM with all panel outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      hi_q         <= '0;
      org_q        <= 1'b0;
      fin_q        <= 1'b0;
      sw_q         <= '0;
      deposit_q    <= 1'b0;
      load_pc_q    <= 1'b0;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        // A start from any resting state begins a fresh load and clears the sticky status.
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q      <= GET_HI;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            run_q        <= 1'b0;
            fin_q        <= 1'b0;
            word_count_q <= '0;
          end
        end

        GET_HI: begin
          if (xfer) begin
            if (byte_data_i[7]) begin
              // Leader/trailer: dropped, but a trailer marked last ends the stream.
              if (byte_last_i) begin
                state_q <= FIN_SETUP;
                sw_q    <= START_PC;
                phase_q <= PH_LOAD;
              end
            end else if (byte_last_i) begin
              // Stream cannot end between the two frames of a word.
              state_q   <= ERR;
              busy_q    <= 1'b0;
              err_q     <= 1'b1;
              deposit_q <= 1'b0;
              load_pc_q <= 1'b0;
            end else begin
              hi_q    <= byte_data_i[5:0];
              org_q   <= byte_data_i[6];
              state_q <= GET_LO;
            end
          end
        end

        GET_LO: begin
          if (xfer) begin
            if (byte_data_i[7] || byte_data_i[6]) begin
              // A low frame never carries leader or origin flags.
              state_q   <= ERR;
              busy_q    <= 1'b0;
              err_q     <= 1'b1;
              deposit_q <= 1'b0;
              load_pc_q <= 1'b0;
            end else begin
              sw_q    <= word_d;
              fin_q   <= byte_last_i;
              phase_q <= PH_LOAD;
              state_q <= SETUP;
            end
          end
        end

        SETUP: begin
          if (phase_end) begin
            state_q   <= PULSE;
            phase_q   <= PH_LOAD;
            load_pc_q <= org_q;
            deposit_q <= ~org_q;
            if (!org_q) begin
              word_count_q <= word_count_d;
            end
          end else begin
            phase_q <= phase_d;
          end
        end

        PULSE: begin
          if (phase_end) begin
            state_q   <= RELEASE;
            phase_q   <= PH_LOAD;
            load_pc_q <= 1'b0;
            deposit_q <= 1'b0;
          end else begin
            phase_q <= phase_d;
          end
        end

        RELEASE: begin
          if (phase_end) begin
            if (fin_q) begin
              state_q <= FIN_SETUP;
              sw_q    <= START_PC;
              phase_q <= PH_LOAD;
            end else begin
              state_q <= GET_HI;
            end
          end else begin
            phase_q <= phase_d;
          end
        end

        FIN_SETUP: begin
          if (phase_end) begin
            state_q   <= FIN_PULSE;
            phase_q   <= PH_LOAD;
            load_pc_q <= 1'b1;
          end else begin
            phase_q <= phase_d;
          end
        end

        FIN_PULSE: begin
          if (phase_end) begin
            state_q   <= FIN_RELEASE;
            phase_q   <= PH_LOAD;
            load_pc_q <= 1'b0;
          end else begin
            phase_q <= phase_d;
          end
        end

        FIN_RELEASE: begin
          if (phase_end) begin
            state_q <= RUN_WAIT;
            phase_q <= PH_LOAD;
          end else begin
            phase_q <= phase_d;
          end
        end

        RUN_WAIT: begin
          if (phase_end) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            run_q   <= AUTO_RUN;
          end else begin
            phase_q <= phase_d;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sw_o         = sw_q;
  assign deposit_o    = deposit_q;
  assign load_pc_o    = load_pc_q;
  assign run_o        = run_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_frame_o  = err_q;
  assign word_count_o = word_count_q;

  // The two panel buttons must never be pressed together.
  a_btn_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(deposit_q && load_pc_q));

  // Busy and the completion flags are mutually exclusive.
  a_busy_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(busy_q && (done_q || err_q)));

  // Every timed phase runs with a loaded, non-zero phase counter.
  a_phase_live: assert property (@(posedge clk_i) disable iff (reset_i)
    ((state_q inside {SETUP, PULSE, RELEASE, FIN_SETUP, FIN_PULSE, FIN_RELEASE, RUN_WAIT})
      |-> (phase_q != '0)));

endmodule

// File: tb/tb_panel_loader.sv
// Bench for panel_loader: a HOLD=10 instance driven from a vector table with a pulse scoreboard,
// plus a HOLD=1 / AUTO_RUN=0 / 2-bit counter instance exercised by a hand-written sequence.
module tb_panel_loader;

  typedef struct packed {
    logic [3:0]       n;
    logic [0:7][7:0]  b;
    logic             gap;
    logic             exp_err;
    logic             exp_run;
    logic [15:0]      exp_wc;
    logic [2:0]       nev;
    logic [0:3][12:0] ev;   // {1=load_pc / 0=deposit, sw}
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // HOLD=10 instance
  logic        rst0, start0, bv0, bl0;
  logic [7:0]  bd0;
  logic        rdy0, dep0, ld0, run0, busy0, done0, err0;
  logic [11:0] sw0;
  logic [15:0] wc0;

  // HOLD=1, AUTO_RUN=0, CNT_W=2 instance
  logic        rst1, start1, bv1, bl1;
  logic [7:0]  bd1;
  logic        rdy1, dep1, ld1, run1, busy1, done1, err1;
  logic [11:0] sw1;
  logic [1:0]  wc1;

  panel_loader #(.HOLD_CYCLES(10)) dut (
    .clk_i(clk), .reset_i(rst0), .start_i(start0), .byte_valid_i(bv0),
    .byte_data_i(bd0), .byte_last_i(bl0), .byte_ready_o(rdy0), .sw_o(sw0),
    .deposit_o(dep0), .load_pc_o(ld0), .run_o(run0), .busy_o(busy0),
    .done_o(done0), .err_frame_o(err0), .word_count_o(wc0)
  );

  panel_loader #(.HOLD_CYCLES(1), .AUTO_RUN(1'b0), .CNT_W(2)) dut1 (
    .clk_i(clk), .reset_i(rst1), .start_i(start1), .byte_valid_i(bv1),
    .byte_data_i(bd1), .byte_last_i(bl1), .byte_ready_o(rdy1), .sw_o(sw1),
    .deposit_o(dep1), .load_pc_o(ld1), .run_o(run1), .busy_o(busy1),
    .done_o(done1), .err_frame_o(err1), .word_count_o(wc1)
  );

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q[$];
  logic mon_en = 1'b1;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] n, input logic [63:0] b, input logic gap,
                              input logic err, input logic run, input logic [15:0] wc,
                              input logic [2:0] nev, input logic [51:0] ev);
    vec_t v;
    v.n = n; v.b = b; v.gap = gap; v.exp_err = err; v.exp_run = run;
    v.exp_wc = wc; v.nev = nev; v.ev = ev;
    return v;
  endfunction

  // Pulse monitor on the HOLD=10 instance: width, overlap, sw stability, expected order.
  initial begin : monitor
    logic        in_p, cur_load, bad_ovl, bad_sw;
    logic [11:0] cur_sw;
    logic [12:0] e;
    int          width;
    in_p = 1'b0; cur_load = 1'b0; bad_ovl = 1'b0; bad_sw = 1'b0; cur_sw = '0; width = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_p = 1'b0;
      end else if (!in_p && (dep0 || ld0)) begin
        in_p = 1'b1; cur_load = ld0; cur_sw = sw0; width = 1;
        bad_ovl = dep0 && ld0; bad_sw = 1'b0;
      end else if (in_p && (dep0 || ld0)) begin
        width++;
        if (dep0 && ld0) bad_ovl = 1'b1;
        if (sw0 != cur_sw) bad_sw = 1'b1;
        if (ld0 != cur_load) bad_sw = 1'b1;
      end else if (in_p) begin
        in_p = 1'b0;
        chk("pulse_width", width, 10);
        chk("pulse_no_overlap", 32'(bad_ovl), 0);
        chk("pulse_sw_stable", 32'(bad_sw), 0);
        if (exp_q.size() == 0) begin
          chk("pulse_unexpected", 32'({cur_load, cur_sw}), 32'h7fff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_event", 32'({cur_load, cur_sw}), 32'(e));
        end
      end
    end
  end

  // Drive a byte stream into the HOLD=10 instance, honouring byte_ready.
  task automatic feed(input vec_t v);
    int   i = 0;
    int   budget = 0;
    logic gapc = 1'b0;
    logic x;
    while (i < int'(v.n) && budget < 3000 && !err0) begin
      gapc = v.gap ? ~gapc : 1'b0;
      if (gapc) begin
        bv0 = 1'b0;
      end else begin
        bv0 = 1'b1; bd0 = v.b[i]; bl0 = (i == int'(v.n) - 1);
      end
      x = bv0 && rdy0;
      @(posedge clk); #1;
      if (x) i++;
      budget++;
    end
    bv0 = 1'b0; bl0 = 1'b0;
    chk("feed_complete", 32'(i < int'(v.n) && !err0), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int budget = 0;
    start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
    chk($sformatf("v%0d_start_busy", idx), 32'(busy0), 1);
    chk($sformatf("v%0d_start_clear", idx), 32'({done0, err0, run0}), 0);
    chk($sformatf("v%0d_start_wc", idx), 32'(wc0), 0);
    for (int k = 0; k < int'(v.nev); k++) exp_q.push_back(v.ev[k]);
    feed(v);
    while (!(done0 || err0) && budget < 2000) begin
      @(posedge clk); #1; budget++;
    end
    chk($sformatf("v%0d_end_reached", idx), 32'(done0 || err0), 1);
    chk($sformatf("v%0d_done", idx), 32'(done0), 32'(!v.exp_err));
    chk($sformatf("v%0d_err_frame", idx), 32'(err0), 32'(v.exp_err));
    chk($sformatf("v%0d_run", idx), 32'(run0), 32'(v.exp_run));
    chk($sformatf("v%0d_busy", idx), 32'(busy0), 0);
    chk($sformatf("v%0d_word_count", idx), 32'(wc0), 32'(v.exp_wc));
    chk($sformatf("v%0d_events_left", idx), exp_q.size(), 0);
    if (!v.exp_err) chk($sformatf("v%0d_final_sw", idx), 32'(sw0), 32'o0200);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] t1b [6];
    vec_t r;
    int   budget;
    int   k;
    logic x;

    vecs[0] = mk(6, {8'o102, 8'o000, 8'o012, 8'o034, 8'o001, 8'o002, 8'o0, 8'o0}, 0, 0, 1, 2, 4,
                 {13'o10200, 13'o01234, 13'o00102, 13'o10200});
    vecs[1] = mk(7, {8'o200, 8'o200, 8'o200, 8'o200, 8'o012, 8'o034, 8'o200, 8'o0}, 0, 0, 1, 1, 2,
                 {13'o01234, 13'o10200, 13'o0, 13'o0});
    vecs[2] = mk(6, {8'o102, 8'o000, 8'o012, 8'o034, 8'o001, 8'o002, 8'o0, 8'o0}, 1, 0, 1, 2, 4,
                 {13'o10200, 13'o01234, 13'o00102, 13'o10200});
    vecs[3] = mk(1, {8'o012, 8'o0, 8'o0, 8'o0, 8'o0, 8'o0, 8'o0, 8'o0}, 0, 1, 0, 0, 0, 52'h0);
    vecs[4] = mk(2, {8'o001, 8'o100, 8'o0, 8'o0, 8'o0, 8'o0, 8'o0, 8'o0}, 0, 1, 0, 0, 0, 52'h0);
    vecs[5] = mk(4, {8'o177, 8'o066, 8'o077, 8'o077, 8'o0, 8'o0, 8'o0, 8'o0}, 0, 0, 1, 1, 3,
                 {13'o17766, 13'o07777, 13'o10200, 13'o0});
    t1b = '{8'o001, 8'o002, 8'o003, 8'o004, 8'o005, 8'o006};

    rst0 = 1'b1; start0 = 1'b0; bv0 = 1'b0; bd0 = '0; bl0 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; bv1 = 1'b0; bd1 = '0; bl1 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    chk("rst_sw", 32'(sw0), 0);
    chk("rst_buttons", 32'({dep0, ld0}), 0);
    chk("rst_run", 32'(run0), 0);
    chk("rst_flags", 32'({busy0, done0, err0}), 0);
    chk("rst_wc", 32'(wc0), 0);
    chk("rst_ready", 32'(rdy0), 0);

    // byte_valid without start in IDLE is ignored
    bv0 = 1'b1; bd0 = 8'o012;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready_low", 32'(rdy0), 0);
    end
    bv0 = 1'b0;
    chk("idle_not_busy", 32'(busy0), 0);

    // Table of full-stream vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in the middle of the second deposit pulse
    mon_en = 1'b0;
    r = mk(4, {8'o012, 8'o034, 8'o001, 8'o002, 8'o0, 8'o0, 8'o0, 8'o0}, 0, 0, 1, 2, 0, 52'h0);
    start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
    feed(r);
    budget = 0;
    while (wc0 != 16'd2 && budget < 200) begin
      @(posedge clk); #1; budget++;
    end
    chk("mid_reset_reached_pulse", 32'(dep0), 1);
    repeat (3) @(posedge clk);
    #1; rst0 = 1'b1;
    @(posedge clk); #1; rst0 = 1'b0;
    chk("mid_reset_deposit", 32'(dep0), 0);
    chk("mid_reset_sw", 32'(sw0), 0);
    chk("mid_reset_busy", 32'(busy0), 0);
    chk("mid_reset_wc", 32'(wc0), 0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("mid_reset_stays_low", 32'({dep0, ld0, busy0}), 0);
    mon_en = 1'b1;
    run_vec(vecs[0], 6);

    // HOLD=1 instance: one-clock phases, 3-clock word latency, ignored start, saturating count
    start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
    chk("h1_ready_after_start", 32'(rdy1), 1);
    bv1 = 1'b1; bd1 = 8'o012; bl1 = 1'b0;
    @(posedge clk); #1;
    bd1 = 8'o034;
    @(posedge clk); #1;
    bv1 = 1'b0;
    chk("h1_setup_sw", 32'(sw1), 32'o1234);
    chk("h1_setup_buttons", 32'({dep1, ld1, rdy1}), 0);
    @(posedge clk); #1;
    chk("h1_pulse_deposit", 32'(dep1), 1);
    chk("h1_pulse_wc", 32'(wc1), 1);
    @(posedge clk); #1;
    chk("h1_release", 32'({dep1, rdy1}), 0);
    @(posedge clk); #1;
    chk("h1_latency3_ready", 32'(rdy1), 1);
    start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
    chk("h1_start_ignored_busy", 32'(busy1), 1);
    chk("h1_start_ignored_wc", 32'(wc1), 1);
    k = 0; budget = 0;
    while (k < 6 && budget < 200) begin
      bv1 = 1'b1; bd1 = t1b[k]; bl1 = (k == 5);
      x = rdy1;
      @(posedge clk); #1;
      if (x) k++;
      budget++;
    end
    bv1 = 1'b0; bl1 = 1'b0;
    budget = 0;
    while (!(done1 || err1) && budget < 200) begin
      @(posedge clk); #1; budget++;
    end
    chk("h1_done", 32'(done1), 1);
    chk("h1_no_err", 32'(err1), 0);
    chk("h1_run_low", 32'(run1), 0);
    chk("h1_busy_low", 32'(busy1), 0);
    chk("h1_wc_saturated", 32'(wc1), 3);
    chk("h1_final_sw", 32'(sw1), 32'o0200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
